// File: rtl/data_sram_responder_if.sv
// Data SRAM-like request/response bus between the EXE-stage master and the data memory slave.
interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: in-order request FIFO, programmable head latency, word memory.
// data_ok is a registered response flag, masked while the resp_stall hook is held.
module data_sram_responder #(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1,
    parameter int MEM_AW  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    data_sram_responder_if.slave       bus,
    input  logic                       resp_stall,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic              wr;
        logic [3:0]        wstrb;
        logic [MEM_AW-1:0] idx;
        logic [31:0]       wdata;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [31:0]   mem [2**MEM_AW];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ok_q, ok_d;
    logic [31:0]   rdata_q, rdata_d;

    entry_t        in_entry;
    entry_t        head_nxt;
    logic [OW-1:0] remain;
    logic          push, pop, new_head, head_nxt_vld, access;
    logic          unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bus.data_sram_addr_ok = bus.data_sram_req & (count_q < OW'(DEPTH));
    assign bus.data_sram_data_ok = pop;
    assign bus.data_sram_rdata   = rdata_q;
    assign outstanding           = count_q;

    assign push = bus.data_sram_req & bus.data_sram_addr_ok;
    assign pop  = ok_q & ~resp_stall;

    assign in_entry = {bus.data_sram_wr, bus.data_sram_wstrb,
                       bus.data_sram_addr[MEM_AW+1:2], bus.data_sram_wdata};

    // size and the non-word address bits play no part in the access
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:MEM_AW+2],
                           bus.data_sram_addr[1:0]};

    always_comb begin
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        remain       = count_q - OW'(pop);
        count_d      = remain + OW'(push);
        new_head     = (pop && (remain != '0)) || ((remain == '0) && push);
        head_nxt_vld = (count_d != '0);
        // a push into an emptying queue becomes head straight from the bus
        head_nxt     = (remain == '0) ? in_entry : fifo_q[rd_ptr_d];

        if (new_head) begin
            cnt_d = CW'(LATENCY - 1);
        end else if ((cnt_q != '0) && !resp_stall) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        ok_d    = head_nxt_vld && (cnt_d == '0);
        // perform the access once, on the edge that first arms this head
        access  = ok_d && (!ok_q || pop);
        rdata_d = head_nxt.wr ? '0 : mem[head_nxt.idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            ok_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            ok_q     <= ok_d;
            if (access) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // storage is deliberately not reset; memory contents survive reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_entry;
        end
        if (access && head_nxt.wr && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (head_nxt.wstrb[b]) begin
                    mem[head_nxt.idx][8*b +: 8] <= head_nxt.wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: LATENCY=1 and LATENCY=4 instances,
// directed scenarios followed by randomized traffic with random stalls.
module tb_data_sram_responder;
    typedef struct {
        int          acc;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst, req, wr, stall, addr_ok, data_ok;
    logic [3:0]  wstrb [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  outs0, outs1;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          rand_en = 1'b0;

    exp_t        sb [2][$];
    logic [31:0] mmem [2][1024];
    int          prog [2];
    int          last_resp [2];

    logic        m_exp;
    int          m_h;
    exp_t        m_e;

    data_sram_responder_if bus0 ();
    data_sram_responder_if bus1 ();

    assign bus0.data_sram_req   = req[0];
    assign bus0.data_sram_wr    = wr[0];
    assign bus0.data_sram_size  = 2'd2;
    assign bus0.data_sram_wstrb = wstrb[0];
    assign bus0.data_sram_addr  = addr[0];
    assign bus0.data_sram_wdata = wdata[0];
    assign addr_ok[0]           = bus0.data_sram_addr_ok;
    assign data_ok[0]           = bus0.data_sram_data_ok;
    assign rdata[0]             = bus0.data_sram_rdata;

    assign bus1.data_sram_req   = req[1];
    assign bus1.data_sram_wr    = wr[1];
    assign bus1.data_sram_size  = 2'd2;
    assign bus1.data_sram_wstrb = wstrb[1];
    assign bus1.data_sram_addr  = addr[1];
    assign bus1.data_sram_wdata = wdata[1];
    assign addr_ok[1]           = bus1.data_sram_addr_ok;
    assign data_ok[1]           = bus1.data_sram_data_ok;
    assign rdata[1]             = bus1.data_sram_rdata;

    data_sram_responder #(.DEPTH(2), .LATENCY(1), .MEM_AW(10)) dut0 (
        .clk(clk), .reset(rst[0]), .bus(bus0), .resp_stall(stall[0]), .outstanding(outs0));
    data_sram_responder #(.DEPTH(2), .LATENCY(4), .MEM_AW(10)) dut1 (
        .clk(clk), .reset(rst[1]), .bus(bus1), .resp_stall(stall[1]), .outstanding(outs1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] outs_of(input int i);
        return (i == 0) ? 32'(outs0) : 32'(outs1);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    // Response rule: the head starts in the cycle after its acceptance or after the
    // previous response, whichever is later; it answers in the cycle where it has
    // seen LATENCY unstalled cycles, and only in an unstalled cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_exp = 1'b0;
            if (sb[i].size() > 0) begin
                m_h = (sb[i][0].acc > last_resp[i]) ? sb[i][0].acc + 1 : last_resp[i] + 1;
                if (cyc >= m_h && !stall[i]) begin
                    prog[i]++;
                    m_exp = (prog[i] == lat(i));
                end
            end
            chk($sformatf("data_ok%0d", i), 32'(data_ok[i]), 32'(m_exp));
            if (m_exp) begin
                m_e = sb[i].pop_front();
                chk($sformatf("rdata%0d", i), rdata[i], m_e.rdata);
                last_resp[i] = cyc;
                prog[i] = 0;
            end
        end
    end

    task automatic cycle_checks(input int i);
        int occ;
        occ = sb[i].size() + ((last_resp[i] == cyc) ? 1 : 0);
        chk($sformatf("addr_ok%0d", i), 32'(addr_ok[i]), 32'(req[i] && (occ < 2)));
        chk($sformatf("outstanding%0d", i), outs_of(i), 32'(occ));
        chk($sformatf("outstanding_max%0d", i), 32'(outs_of(i) <= 2), 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            #6;
            cycle_checks(0);
            cycle_checks(1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int i, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d);
        logic acc;
        int   idx;
        acc = 1'b0;
        req[i] = 1'b1; wr[i] = w; wstrb[i] = s; addr[i] = a; wdata[i] = d;
        for (int t = 0; t < 64 && !acc; t++) begin
            #6;
            cycle_checks(i);
            acc = addr_ok[i];
            if (acc) begin
                idx = int'((a >> 2) % 1024);
                sb[i].push_back('{cyc, w ? 32'h0 : mmem[i][idx]});
                if (w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) mmem[i][idx][8*b +: 8] = d[8*b +: 8];
                    end
                end
            end
            @(posedge clk); #1;
        end
        if (!acc) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
        req[i] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_en) begin
                stall[0] = ($urandom_range(0, 3) == 0);
                stall[1] = ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [31:0] a;
        rst = 2'b11; req = '0; wr = '0; stall = '0;
        for (int i = 0; i < 2; i++) begin
            wstrb[i] = '0; addr[i] = '0; wdata[i] = '0;
            prog[i] = 0; last_resp[i] = -10;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_data_ok%0d", i), 32'(data_ok[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
            chk($sformatf("rst_outstanding%0d", i), outs_of(i), 32'd0);
            chk($sformatf("rst_addr_ok%0d", i), 32'(addr_ok[i]), 32'd0);
        end
        rst = 2'b00;
        @(posedge clk); #1;

        // write/read, byte-lane write, address alias on the LATENCY=1 instance
        send(0, 1'b1, 4'hF, 32'h1C00_0010, 32'h1234_5678);
        send(0, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
        send(0, 1'b1, 4'b0100, 32'h1C00_0010, 32'hAAAA_AAAA);
        send(0, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
        tick(3);
        send(0, 1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D);
        send(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
        send(0, 1'b1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF);
        send(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
        tick(3);

        // stall hook: read accepted, then three stalled cycles
        send(0, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
        stall[0] = 1'b1;
        tick(3);
        stall[0] = 1'b0;
        tick(3);

        // full queue on the LATENCY=4 instance, req held high
        send(1, 1'b1, 4'hF, 32'h0000_0080, 32'h5A5A_A5A5);
        send(1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        send(1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        tick(14);

        // reset with two reads outstanding
        send(1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        send(1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = data_ok[1];
        end
        chk("rst_mid_first_resp", 32'(got), 32'd1);
        #1;
        rst[1] = 1'b1;
        sb[1].delete();
        prog[1] = 0;
        last_resp[1] = -10;
        #1;
        chk("rst_mid_data_ok", 32'(data_ok[1]), 32'd0);
        chk("rst_mid_outstanding", outs_of(1), 32'd0);
        chk("rst_mid_rdata", rdata[1], 32'd0);
        #2;
        rst[1] = 1'b0;
        @(posedge clk); #1;
        tick(8);
        send(1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        tick(6);

        // randomized traffic over 16 aliased words per instance
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 16; w++) begin
                send(i, 1'b1, 4'hF, 32'h3000_0000 + 32'(w * 4), $urandom);
            end
        end
        tick(6);
        rand_en = 1'b1;
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick(1);
            end else begin
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 15));
                send(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                     a, $urandom);
            end
        end
        rand_en = 1'b0;
        tick(1);
        stall = 2'b00;
        for (int t = 0; t < 300 && (sb[0].size() + sb[1].size()) > 0; t++) tick(1);
        chk("drain_empty", 32'(sb[0].size() + sb[1].size()), 32'd0);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
